// File: rtl/multicycle_alu.sv
// Handshaked ALU with a registered result: single-cycle logic ops, iterative shift-add multiply,
// and an optional iterative restoring signed divide/remainder enabled by the ALU_DIV_EN macro.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic [3:0]       ALUCtrl_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);
  localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

  state_t           state_q;
  logic [SH_W:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q, valid_q;

  logic             accept;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] alu_res, acc_nx;

  assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE && ready_i);
  assign accept  = valid_i && ready_o;
  assign shamt   = data2_i[SH_W-1:0];
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign Zero_o  = zero_q;

  always_comb begin
    alu_res = '0;
    unique case (ALUCtrl_i)
      4'b0000: alu_res = data1_i & data2_i;
      4'b0001: alu_res = data1_i ^ data2_i;
      4'b0010: alu_res = data1_i << shamt;
      4'b0011: alu_res = data1_i + data2_i;
      4'b0100: alu_res = data1_i - data2_i;
      4'b0110: alu_res = WIDTH'($signed(data1_i) >>> shamt);
      4'b0111: alu_res = data1_i | data2_i;
      4'b1000: alu_res = data1_i >> shamt;
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
      default: alu_res = '0;
    endcase
  end

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_DIV_EN
  logic             rem_q, negq_q, negr_q, divz_q;
  logic             is_div, ge;
  logic [WIDTH-1:0] rsh, r_nx, q_nx, div_res, abs_a, abs_b;

  assign is_div = (ALUCtrl_i == 4'b1010) || (ALUCtrl_i == 4'b1011);
  assign abs_a  = data1_i[WIDTH-1] ? -data1_i : data1_i;
  assign abs_b  = data2_i[WIDTH-1] ? -data2_i : data2_i;
  // Partial remainder stays below the divisor, so the dropped top bit is always zero.
  assign rsh    = {acc_q[WIDTH-2:0], mplier_q[WIDTH-1]};
  assign ge     = rsh >= mcand_q;
  assign r_nx   = ge ? rsh - mcand_q : rsh;
  assign q_nx   = {mplier_q[WIDTH-2:0], ge};

  always_comb begin
    if (rem_q)       div_res = negr_q ? -r_nx : r_nx;
    else if (divz_q) div_res = '1;
    else             div_res = negq_q ? -q_nx : q_nx;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_DIV_EN
      rem_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      divz_q   <= 1'b0;
`endif
    end else if (accept) begin
      if (ALUCtrl_i == 4'b0101) begin
        state_q  <= S_MUL;
        cnt_q    <= (SH_W+1)'(WIDTH);
        acc_q    <= '0;
        mcand_q  <= data1_i;
        mplier_q <= data2_i;
        valid_q  <= 1'b0;
`ifdef ALU_DIV_EN
      end else if (is_div) begin
        state_q  <= S_DIV;
        cnt_q    <= (SH_W+1)'(WIDTH);
        acc_q    <= '0;
        mcand_q  <= abs_b;
        mplier_q <= abs_a;
        rem_q    <= ALUCtrl_i[0];
        negq_q   <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
        negr_q   <= data1_i[WIDTH-1];
        divz_q   <= (data2_i == '0);
        valid_q  <= 1'b0;
`endif
      end else begin
        state_q <= S_DONE;
        data_q  <= alu_res;
        zero_q  <= (alu_res == '0);
        valid_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        S_MUL: begin
          acc_q    <= acc_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == (SH_W+1)'(1)) begin
            state_q <= S_DONE;
            data_q  <= acc_nx;
            zero_q  <= (acc_nx == '0);
            valid_q <= 1'b1;
          end
        end
`ifdef ALU_DIV_EN
        S_DIV: begin
          acc_q    <= r_nx;
          mplier_q <= q_nx;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == (SH_W+1)'(1)) begin
            state_q <= S_DONE;
            data_q  <= div_res;
            zero_q  <= (div_res == '0);
            valid_q <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          if (ready_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised, handshaked ALU for the pipelined CPU's execute stage.
- Extends the combinational ALU op set with a registered result and a 4-bit op code.
- Multiply runs as an iterative radix-2 shift-add; optional signed divide/remainder runs as iterative restoring division.
- The execute stage stalls on ready_o and consumes the result on valid_o.

Parameters:
- WIDTH, 32: operand/result width; power of two, >= 8. localparam SH_W = $clog2(WIDTH).

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  operands/op presented
- ready_o  out  1  block can accept operation this cycle
- data1_i  in  WIDTH  operand A, signed
- data2_i  in  WIDTH  operand B, signed
- ALUCtrl_i  in  4  op code
- valid_o  out  1  result available, held until accepted
- ready_i  in  1  consumer accepts result
- data_o  out  WIDTH  result
- Zero_o  out  1  result == 0, registered with data_o

Behaviour:
- Op codes:
  - 0000 AND, 0001 XOR, 0010 SLL, 0011 ADD, 0100 SUB, 0101 MUL, 0110 SRA, 0111 OR
  - 1000 SRL, 1001 SLT, 1010 DIV, 1011 REM
  - Others give result 0, single-cycle.
- Arithmetic and width rules:
  - Shift amount is data2_i[SH_W-1:0].
  - SLT result is 1 if A<B signed, else 0.
  - ADD/SUB/MUL wrap modulo 2^WIDTH; MUL returns the low WIDTH bits of the product.
- States: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- Reset values: valid_o=0, data_o=0, Zero_o=0, iteration counter=0; ready_o reads 1 out of reset.
- Accept: an op is accepted on an edge where valid_i && ready_o. Operands and op are captured; the inputs are ignored afterwards.
- ready_o = (state==IDLE) || (state==DONE && ready_i). This is a combinational path from ready_i and allows back-to-back accepts.
- Single-cycle ops: accept -> DONE. valid_o is high on the cycle after the accept edge (latency 1).
- MUL:
  - Accept -> MUL state; counter loads WIDTH.
  - Each cycle: the multiplier LSB conditionally adds the multiplicand to the accumulator, the multiplicand shifts left, the multiplier shifts right, and the counter decrements.
  - At counter==1 the state goes to DONE. valid_o rises WIDTH+1 cycles after the accept edge.
- DIV/REM (macro only): same timing as MUL, WIDTH iterations, one quotient bit per cycle on operand magnitudes; signs are fixed on entry to DONE.
- DONE:
  - data_o/Zero_o/valid_o stay stable until valid_o && ready_i.
  - On that edge: if valid_i is also high, the new op is accepted (valid_o stays high for a single-cycle op, else drops and the state goes to MUL/DIV); otherwise the state goes to IDLE and valid_o goes to 0.
- Zero_o is computed from the final result and written in the same edge as data_o.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight op is discarded and no result is produced.
- valid_i while busy (MUL/DIV, or DONE without ready_i): not accepted. The producer must hold its inputs.

Optional Feature:
- Macro ALU_DIV_EN.
- Defined:
  - DIV/REM use RISC-V signed semantics, quotient truncating toward zero, remainder taking the sign of the dividend.
  - Divide by zero: quotient all ones, remainder = dividend.
  - Overflow case (-2^(WIDTH-1) / -1): quotient = dividend, remainder 0. Both special cases still take the full WIDTH+1 latency.
- Undefined: 1010/1011 are unknown ops (result 0, Zero_o=1, latency 1), and no DIV state or divider logic exists.

Test Plan:
- Reset then ADD: A=7, B=-3 accepted -> next cycle valid_o=1, data_o=4, Zero_o=0. With ready_i=1 and no new valid_i, valid_o=0 the following cycle.
- SUB/SRA/Zero: SUB 5-5 -> data_o=0, Zero_o=1. SRA A=0x80000000, B=0x24 (shamt 4) -> 0xF8000000.
- MUL latency and wrap:
  - A=-6, B=7 -> valid_o exactly 33 cycles after accept, data_o=0xFFFFFFD6 (-42), ready_o=0 throughout.
  - A=0x10000, B=0x10000 -> data_o=0.
- Back-to-back and backpressure:
  - ADD result held with ready_i=0 for 5 cycles: data_o stable, ready_o=0, new valid_i ignored.
  - Then ready_i=1 with valid_i=1 XOR 0xF0^0xFF -> next cycle data_o=0x0F with valid_o continuously high.
- Reset mid-MUL: assert rst_i 10 cycles into MUL -> valid_o=0, data_o=0, ready_o=1 immediately. A fresh ADD 1+1 completes with 2.
- ALU_DIV_EN:
  - -7/2 -> -3; -7 REM 2 -> -1.
  - 5/0 -> 0xFFFFFFFF, REM 5.
  - 0x80000000 / -1 -> 0x80000000, REM 0.
  - All complete at WIDTH+1 cycles. Without the macro, DIV gives 0 after 1 cycle.
